// File: rtl/axis_vector_loader.sv
`timescale 1ns/1ps
// axis_vector_loader
//   Stream sink that captures exactly DEPTH words from a valid/next_data/last
//   source into an internal buffer, flags short/long vectors, and exposes the
//   buffer on a registered random-access read port (1-cycle latency).
//   Optional feature macro: AXIS_LOADER_CHECKSUM_EN (running XOR of stored words).
module axis_vector_loader #(
    parameter int DEPTH      = 33,
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  us_valid,
    input  logic [WIDTH-1:0]      us_data,
    input  logic                  us_last,
    output logic                  us_next_data,
    output logic                  busy,
    output logic                  done,
    output logic                  len_error,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    output logic [WIDTH-1:0]      checksum
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  len_err_q, len_err_d;
    logic [WIDTH-1:0]      rd_data_q;
    logic [WIDTH-1:0]      mem_q [DEPTH];

    logic                  beat;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  rd_in_range;

`ifdef AXIS_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0]      cks_q, cks_d;
`endif

    // A beat transfers only while the registered ready is high, so no beat can
    // slip through in the cycle the FSM enters DONE.
    assign beat        = us_valid && busy_q;
    assign wr_addr     = count_q[ADDR_WIDTH-1:0];
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);

    // Next-state and control decode for the load sequence.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        done_d    = done_q;
        len_err_d = len_err_q;
        wr_en     = 1'b0;
`ifdef AXIS_LOADER_CHECKSUM_EN
        cks_d     = cks_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    count_d   = '0;
                    done_d    = 1'b0;
                    len_err_d = 1'b0;
`ifdef AXIS_LOADER_CHECKSUM_EN
                    cks_d     = '0;
`endif
                end
            end
            S_LOAD: begin
                if (beat) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 1'b1;
`ifdef AXIS_LOADER_CHECKSUM_EN
                    cks_d   = cks_q ^ us_data;
`endif
                    if (us_last) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        len_err_d = (count_q != LAST_IDX);
                    end else if (count_q == LAST_IDX) begin
                        // Buffer full but the source keeps going: swallow the tail.
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (beat && us_last) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    len_err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_LOAD) || (state_d == S_DRAIN);
    end

    // FSM state and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            len_err_q <= len_err_d;
        end
    end

    // Vector buffer write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= us_data;
        end
    end

    // Registered read port; a same-cycle write is seen on the following read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_in_range ? mem_q[rd_addr] : '0;
        end
    end

`ifdef AXIS_LOADER_CHECKSUM_EN
    // Running XOR over the words actually stored in the buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cks_q <= '0;
        end else begin
            cks_q <= cks_d;
        end
    end
    assign checksum = cks_q;
`else
    assign checksum = '0;
`endif

    assign us_next_data = busy_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign len_error    = len_err_q;
    assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_axis_vector_loader.sv
`timescale 1ns/1ps
// Self-checking bench for axis_vector_loader: random vectors of correct,
// short and long length, valid gaps, restart-while-busy, mid-load reset and
// the checksum pattern, checked against a buffer/length/XOR model.
module tb_axis_vector_loader;

    localparam int DEPTH = 33;
    localparam int WIDTH = 32;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             us_valid = 1'b0;
    logic [WIDTH-1:0] us_data = '0;
    logic             us_last = 1'b0;
    logic             us_next_data;
    logic             busy;
    logic             done;
    logic             len_error;
    logic [AW-1:0]    rd_addr = '0;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] checksum;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [DEPTH];
    bit          known [DEPTH];
    logic [31:0] vec   [64];
    logic [31:0] cks_m = '0;

    axis_vector_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .us_valid     (us_valid),
        .us_data      (us_data),
        .us_last      (us_last),
        .us_next_data (us_next_data),
        .busy         (busy),
        .done         (done),
        .len_error    (len_error),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .checksum     (checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cks();
`ifdef AXIS_LOADER_CHECKSUM_EN
        return cks_m;
`else
        return 32'h0;
`endif
    endfunction

    task automatic rand_vec(input int n);
        for (int i = 0; i < n; i++) vec[i] = $urandom();
    endtask

    // A vector of n words leaves min(n, DEPTH) of them in the buffer.
    task automatic apply_model(input int n);
        for (int i = 0; i < n && i < DEPTH; i++) begin
            mem_m[i] = vec[i];
            known[i] = 1'b1;
            cks_m    = cks_m ^ vec[i];
        end
    endtask

    task automatic start_load();
        rd_addr = '0;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        cks_m   = '0;
        check("busy_after_start", {31'b0, busy}, 32'd1);
        check("done_cleared", {31'b0, done}, 32'd0);
    endtask

    // Offer vec[first..n-1]; last flagged on word n-1 when mark_last is set.
    task automatic send(input int first, input int n, input bit mark_last, input int gap_pct);
        int i;
        int cyc;
        bit v;
        bit rdy;
        i   = first;
        cyc = 0;
        while (i < n && cyc < 3000) begin
            v        = ($urandom_range(99) >= gap_pct);
            rdy      = us_next_data;
            us_valid = v;
            us_data  = vec[i];
            us_last  = mark_last && (i == n - 1);
            @(posedge clk); #1;
            cyc++;
            if (v && rdy) begin
                if (i == 0 && known[0])
                    check("rd_old_word_on_write", rd_data, mem_m[0]);
                i++;
            end
        end
        us_valid = 1'b0;
        us_last  = 1'b0;
        check("beats_accepted", i, n);
    endtask

    task automatic check_done(input bit exp_err);
        check("done", {31'b0, done}, 32'd1);
        check("len_error", {31'b0, len_error}, {31'b0, exp_err});
        check("busy_done", {31'b0, busy}, 32'd0);
        check("ready_done", {31'b0, us_next_data}, 32'd0);
        check("checksum", checksum, exp_cks());
    endtask

    task automatic check_mem();
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            @(posedge clk); #1;
            if (known[a]) check($sformatf("rd[%0d]", a), rd_data, mem_m[a]);
        end
        rd_addr = AW'(40);
        @(posedge clk); #1;
        check("rd_out_of_range_40", rd_data, 32'h0);
        rd_addr = '1;
        @(posedge clk); #1;
        check("rd_out_of_range_max", rd_data, 32'h0);
        rd_addr = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'b0, us_next_data}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_len_error"}, {31'b0, len_error}, 32'd0);
        check({tag, "_rd_data"}, rd_data, 32'h0);
        check({tag, "_checksum"}, checksum, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = '0;
            known[i] = 1'b0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_done", {31'b0, done}, 32'd0);
        check("idle_ready", {31'b0, us_next_data}, 32'd0);

        // Full-length vector, no gaps
        rand_vec(DEPTH);
        start_load();
        send(0, DEPTH, 1'b1, 0);
        apply_model(DEPTH);
        check_done(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_done(1'b0);
        check_mem();

        // Full-length vector with valid low about 2 of 3 cycles
        rand_vec(DEPTH);
        start_load();
        send(0, DEPTH, 1'b1, 67);
        apply_model(DEPTH);
        check_done(1'b0);
        check_mem();

        // start while loading is ignored
        rand_vec(DEPTH);
        start_load();
        send(0, 5, 1'b0, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_ignored_start", {31'b0, busy}, 32'd1);
        send(5, DEPTH, 1'b1, 30);
        apply_model(DEPTH);
        check_done(1'b0);
        check_mem();

        // Short vector of 20 words: tail of buffer keeps previous contents
        rand_vec(20);
        start_load();
        send(0, 20, 1'b1, 20);
        apply_model(20);
        check_done(1'b1);
        check_mem();

        // Long vector of 40 words: first DEPTH stored, rest drained
        rand_vec(40);
        start_load();
        send(0, 40, 1'b1, 10);
        apply_model(40);
        check_done(1'b1);
        check_mem();

        // Reset after 10 beats, then a clean reload
        rand_vec(DEPTH);
        start_load();
        send(0, 10, 1'b0, 0);
        apply_model(10);
        rst = 1'b0;
        #1;
        cks_m = '0;
        check_reset_outputs("midload_reset");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("held_reset");
        rst = 1'b1;
        @(posedge clk); #1;
        rand_vec(DEPTH);
        start_load();
        send(0, DEPTH, 1'b1, 25);
        apply_model(DEPTH);
        check_done(1'b0);
        check_mem();

        // Checksum pattern
        for (int i = 0; i < DEPTH; i++) vec[i] = 32'h0;
        vec[0] = 32'h3F80_0000;
        vec[1] = 32'h4000_0000;
        start_load();
        send(0, DEPTH, 1'b1, 0);
        apply_model(DEPTH);
        check_done(1'b0);
`ifdef AXIS_LOADER_CHECKSUM_EN
        check("checksum_pattern", checksum, 32'h7F80_0000);
`else
        check("checksum_pattern", checksum, 32'h0);
`endif
        check_mem();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
